// File: rtl/lr_stack_pkg.sv
// rtl/lr_stack_pkg.sv - shared CPU constants and link-register stack operation decode
package lr_stack_pkg;

  // Address width shared by the jump unit, program counter and link-register stack
  localparam int LR_WIDTH = 8;
  // Return-address entries held by the link-register stack
  localparam int LR_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVF,
    OP_UNF
  } lr_op_e;

  // A simultaneous push and pop on an empty stack degenerates to a plain push;
  // on a non-empty stack it replaces the top entry, even when full.
  function automatic lr_op_e decode_op(input logic push, input logic pop,
                                       input logic is_empty, input logic is_full);
    lr_op_e op;
    op = OP_HOLD;
    case ({push, pop})
      2'b10:   op = is_full  ? OP_OVF  : OP_PUSH;
      2'b01:   op = is_empty ? OP_UNF  : OP_POP;
      2'b11:   op = is_empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lr_stack_mem.sv
// rtl/lr_stack_mem.sv - return-address register array with one write port and a read mux
module lr_stack_mem
  import lr_stack_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH,
  parameter int DEPTH = LR_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] entries [DEPTH];

  // Entry storage: cleared asynchronously on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  // Combinational read of the addressed entry
  always_comb begin
    rdata = entries[raddr];
  end

endmodule

// File: rtl/lr_stack.sv
// rtl/lr_stack.sv - link-register return-address stack with saturating pointer and sticky errors
module lr_stack
  import lr_stack_pkg::*;
#(
  parameter int WIDTH = LR_WIDTH,
  parameter int DEPTH = LR_DEPTH,
  localparam int SPW  = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             clr_err,
  output logic [WIDTH-1:0] lr_addr,
  output logic             empty,
  output logic             full,
  output logic [SPW-1:0]   count,
  output logic             ovf,
  output logic             unf
);

  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_next;
  logic             ovf_evt;
  logic             unf_evt;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_data;
  lr_op_e           op;

  // Status decode from the registered pointer only
  always_comb begin
    empty   = (sp == '0);
    full    = (sp == SPW'(DEPTH));
    count   = sp;
    top_idx = AW'(sp - SPW'(1));
    lr_addr = empty ? '0 : top_data;
  end

  // Push/pop decode: next pointer, write strobe/address and error events
  always_comb begin
    op        = decode_op(push, pop, empty, full);
    sp_next   = sp;
    mem_we    = 1'b0;
    mem_waddr = AW'(sp);
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    case (op)
      OP_PUSH: begin
        mem_we  = 1'b1;
        sp_next = sp + SPW'(1);
      end
      OP_POP: begin
        sp_next = sp - SPW'(1);
      end
      OP_REPLACE: begin
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
      OP_OVF:  ovf_evt = 1'b1;
      OP_UNF:  unf_evt = 1'b1;
      default: ;
    endcase
  end

  // Pointer and sticky flags; an error event outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_next;
      ovf <= ovf_evt | (ovf & ~clr_err);
      unf <= unf_evt | (unf & ~clr_err);
    end
  end

  lr_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (push_addr),
    .raddr (top_idx),
    .rdata (top_data)
  );

endmodule

// File: tb/tb_lr_stack.sv
// tb/tb_lr_stack.sv - directed self-checking bench for lr_stack at WIDTH=8, DEPTH=4
module tb_lr_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_addr = 8'h00;
  logic       clr_err = 1'b0;
  logic [7:0] lr_addr;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       ovf;
  logic       unf;

  int n_cmp = 0;
  int n_bad = 0;

  lr_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .clr_err   (clr_err),
    .lr_addr   (lr_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge
  task automatic step(input logic p, input logic q, input logic [7:0] a, input logic c);
    @(negedge clk);
    push = p; pop = q; push_addr = a; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; push_addr = 8'h00; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if (lr_addr !== 8'h00) begin n_bad++; $display("FAIL rst_lr: got %h exp 00", lr_addr); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b exp 0", full); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d exp 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b exp 0", ovf); end
    n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL rst_unf: got %b exp 0", unf); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_idle_empty: got %b exp 1", empty); end
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b0, 8'h10, 1'b0);
    n_cmp++; if (lr_addr !== 8'h10) begin n_bad++; $display("FAIL pp_lr1: got %h exp 10", lr_addr); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL pp_empty1: got %b exp 0", empty); end
    step(1'b1, 1'b0, 8'h20, 1'b0);
    n_cmp++; if (lr_addr !== 8'h20) begin n_bad++; $display("FAIL pp_lr2: got %h exp 20", lr_addr); end
    step(1'b1, 1'b0, 8'h30, 1'b0);
    n_cmp++; if (lr_addr !== 8'h30) begin n_bad++; $display("FAIL pp_lr3: got %h exp 30", lr_addr); end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL pp_count3: got %0d exp 3", count); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (lr_addr !== 8'h30 || count !== 3'd3) begin n_bad++; $display("FAIL pp_hold: got %h/%0d exp 30/3", lr_addr, count); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (lr_addr !== 8'h20) begin n_bad++; $display("FAIL pp_pop1: got %h exp 20", lr_addr); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (lr_addr !== 8'h10) begin n_bad++; $display("FAIL pp_pop2: got %h exp 10", lr_addr); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL pp_count1: got %0d exp 1", count); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (empty !== 1'b1 || lr_addr !== 8'h00 || unf !== 1'b0) begin n_bad++; $display("FAIL pp_drain: got empty=%b lr=%h unf=%b exp 1/00/0", empty, lr_addr, unf); end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0);
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL ov_notfull3: got %b exp 0", full); end
    step(1'b1, 1'b0, 8'h04, 1'b0);
    n_cmp++; if (full !== 1'b1 || count !== 3'd4) begin n_bad++; $display("FAIL ov_full4: got full=%b count=%0d exp 1/4", full, count); end
    step(1'b1, 1'b0, 8'h05, 1'b0);
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL ov_full: got %b exp 1", full); end
    n_cmp++; if (lr_addr !== 8'h04) begin n_bad++; $display("FAIL ov_lr: got %h exp 04", lr_addr); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ov_ovf: got %b exp 1", ovf); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ov_count: got %0d exp 4", count); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ov_clr: got %b exp 0", ovf); end
    step(1'b1, 1'b0, 8'h06, 1'b1);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ov_evt_wins: got %b exp 1", ovf); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    n_cmp++; if (lr_addr !== 8'h77 || count !== 3'd4 || ovf !== 1'b0 || unf !== 1'b0) begin n_bad++; $display("FAIL ov_replace_full: got lr=%h count=%0d ovf=%b unf=%b exp 77/4/0/0", lr_addr, count, ovf, unf); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (lr_addr !== 8'h03) begin n_bad++; $display("FAIL ov_pop_after: got %h exp 03", lr_addr); end
    do_reset();
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL un_unf: got %b exp 1", unf); end
    n_cmp++; if (lr_addr !== 8'h00 || count !== 3'd0) begin n_bad++; $display("FAIL un_state: got lr=%h count=%0d exp 00/0", lr_addr, count); end
    step(1'b1, 1'b1, 8'h69, 1'b0);
    n_cmp++; if (lr_addr !== 8'h69) begin n_bad++; $display("FAIL un_pp_lr: got %h exp 69", lr_addr); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL un_pp_count: got %0d exp 1", count); end
    n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL un_sticky: got %b exp 1", unf); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL un_clr: got %b exp 0", unf); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_replace();
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    step(1'b1, 1'b0, 8'hBB, 1'b0);
    n_cmp++; if (lr_addr !== 8'hBB) begin n_bad++; $display("FAIL rp_top: got %h exp BB", lr_addr); end
    step(1'b1, 1'b1, 8'h69, 1'b0);
    n_cmp++; if (lr_addr !== 8'h69) begin n_bad++; $display("FAIL rp_lr: got %h exp 69", lr_addr); end
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL rp_count: got %0d exp 2", count); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (lr_addr !== 8'hAA) begin n_bad++; $display("FAIL rp_pop: got %h exp AA", lr_addr); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    n_cmp++; if (lr_addr !== 8'h22 || count !== 3'd3) begin n_bad++; $display("FAIL ar_pre: got lr=%h count=%0d exp 22/3", lr_addr, count); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (lr_addr !== 8'h00) begin n_bad++; $display("FAIL ar_lr: got %h exp 00", lr_addr); end
    n_cmp++; if (empty !== 1'b1 || count !== 3'd0) begin n_bad++; $display("FAIL ar_empty: got empty=%b count=%0d exp 1/0", empty, count); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (unf !== 1'b1 || count !== 3'd0) begin n_bad++; $display("FAIL ar_pop_empty: got unf=%b count=%0d exp 1/0", unf, count); end
    step(1'b1, 1'b0, 8'h33, 1'b1);
    n_cmp++; if (lr_addr !== 8'h33 || count !== 3'd1 || unf !== 1'b0) begin n_bad++; $display("FAIL ar_push: got lr=%h count=%0d unf=%b exp 33/1/0", lr_addr, count, unf); end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if (empty !== 1'b1 || lr_addr !== 8'h00) begin n_bad++; $display("FAIL ar_stale: got empty=%b lr=%h exp 1/00", empty, lr_addr); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
